// File: rtl/blink_pkg.sv
// Shared definitions for the blink period meter: state encoding, default width
// and the clamped tolerance window helpers.
`timescale 1ns/1ps
package blink_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam int DEFAULT_CNT_W = 32;

  // Lower edge of the accepted window; a tolerance larger than the nominal clamps to 0.
  function automatic logic [63:0] lower_bound(input logic [63:0] nominal, input logic [63:0] tol);
    return (nominal > tol) ? (nominal - tol) : 64'd0;
  endfunction

  function automatic logic [63:0] upper_bound(input logic [63:0] nominal, input logic [63:0] tol);
    return nominal + tol;
  endfunction

endpackage

// File: rtl/blink_period_meter_if.sv
// Result port of the blink period meter: valid/ready result plus sticky status
// and the optional min/max statistics.
`timescale 1ns/1ps
interface blink_period_meter_if
  import blink_pkg::*;
#(
  parameter int cnt_w = DEFAULT_CNT_W
);

  logic [cnt_w-1:0] period_o;
  logic             period_valid_o;
  logic             period_ready_i;
  logic             ok_o;
  logic             sat_o;
  logic             overrun_o;
  logic [cnt_w-1:0] min_o;
  logic [cnt_w-1:0] max_o;

  modport master (
    output period_o, period_valid_o, ok_o, sat_o, overrun_o, min_o, max_o,
    input  period_ready_i
  );

  modport slave (
    input  period_o, period_valid_o, ok_o, sat_o, overrun_o, min_o, max_o,
    output period_ready_i
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus delay flop; pulse is high for one cycle after
// either direction of change on the asynchronous input.
`timescale 1ns/1ps
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta_q <= sig;
      sync_q <= meta_q;
      sync_d <= sync_q;
    end
  end

  assign pulse = sync_q ^ sync_d;

endmodule

// File: rtl/blink_period_meter.sv
// Measures clk cycles between blinky toggles and reports each interval with a
// tolerance verdict. Define BLINK_PERIOD_METER_STATS_EN to track min/max intervals.
`timescale 1ns/1ps
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int clk_freq_hz = 50_000,
  parameter int tol_cycles  = 0,
  parameter int cnt_w       = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_i,
  blink_period_meter_if.master res
);

  localparam logic [cnt_w-1:0] cnt_max = '1;
  localparam logic [63:0]      lo64    = lower_bound(64'(clk_freq_hz), 64'(tol_cycles));
  localparam logic [63:0]      hi64    = upper_bound(64'(clk_freq_hz), 64'(tol_cycles));
  localparam logic [cnt_w:0]   lo_b    = lo64[cnt_w:0];
  localparam logic [cnt_w:0]   hi_b    = hi64[cnt_w:0];

  logic [0:0]       state;
  logic [cnt_w-1:0] cnt;
  logic             sat;
  logic             pulse;
  logic             cap;
  logic             cap_ok;
  logic             load;
  logic             drop;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig   (sig_i),
    .pulse (pulse)
  );

  always_comb begin
    cap    = (state == ST_MEASURE) && pulse;
    cap_ok = !sat && ({1'b0, cnt} >= lo_b) && ({1'b0, cnt} <= hi_b);
    load   = cap && (!res.period_valid_o || res.period_ready_i);
    drop   = cap && res.period_valid_o && !res.period_ready_i;
  end

  // The first edge only arms; every later edge closes one interval and opens the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pulse) begin
            state <= ST_MEASURE;
            cnt   <= cnt_w'(1);
          end
        end
        default: begin
          if (pulse) begin
            cnt <= cnt_w'(1);
            sat <= 1'b0;
          end else if (cnt == cnt_max) begin
            sat <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // A result arriving while the previous one is still unaccepted is lost, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res.period_o       <= '0;
      res.period_valid_o <= 1'b0;
      res.ok_o           <= 1'b0;
      res.sat_o          <= 1'b0;
      res.overrun_o      <= 1'b0;
    end else begin
      if (load) begin
        res.period_o       <= cnt;
        res.ok_o           <= cap_ok;
        res.sat_o          <= sat;
        res.period_valid_o <= 1'b1;
      end else if (res.period_valid_o && res.period_ready_i) begin
        res.period_valid_o <= 1'b0;
      end
      if (drop) begin
        res.overrun_o <= 1'b1;
      end
    end
  end

`ifdef BLINK_PERIOD_METER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res.min_o <= '1;
      res.max_o <= '0;
    end else if (load && !sat) begin
      if (cnt < res.min_o) begin
        res.min_o <= cnt;
      end
      if (cnt > res.max_o) begin
        res.max_o <= cnt;
      end
    end
  end
`else
  assign res.min_o = '1;
  assign res.max_o = '0;
`endif

endmodule

// File: tb/tb_blink_period_meter.sv
// Scoreboard bench for blink_period_meter: two instances (wide/tolerant and
// narrow/exact) driven with toggle timings, checked against an interval model.
`timescale 1ns/1ps
module tb_blink_period_meter;

  localparam int freq_a = 1000;
  localparam int tol_a  = 2;
  localparam int w_a    = 32;
  localparam int freq_c = 50;
  localparam int tol_c  = 0;
  localparam int w_c    = 8;

  typedef struct {
    longint load;
    longint period;
    bit     ok;
    bit     sat;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_a = 1'b0;
  logic sig_c = 1'b0;
  logic rdy_a = 1'b1;
  logic rdy_c = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  always #5 clk = ~clk;

  blink_period_meter_if #(.cnt_w(w_a)) bus_a ();
  blink_period_meter_if #(.cnt_w(w_c)) bus_c ();

  assign bus_a.period_ready_i = rdy_a;
  assign bus_c.period_ready_i = rdy_c;

  blink_period_meter #(.clk_freq_hz(freq_a), .tol_cycles(tol_a), .cnt_w(w_a)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .sig_i (sig_a),
    .res   (bus_a.master)
  );

  blink_period_meter #(.clk_freq_hz(freq_c), .tol_cycles(tol_c), .cnt_w(w_c)) dut_c (
    .clk   (clk),
    .rst   (rst),
    .sig_i (sig_c),
    .res   (bus_c.master)
  );

  logic [31:0] per_w [2];
  logic [31:0] min_w [2];
  logic [31:0] max_w [2];
  logic        val_w [2];
  logic        ok_w  [2];
  logic        sat_w [2];
  logic        ovr_w [2];

  assign per_w[0] = bus_a.period_o;
  assign per_w[1] = 32'(bus_c.period_o);
  assign min_w[0] = bus_a.min_o;
  assign min_w[1] = 32'(bus_c.min_o);
  assign max_w[0] = bus_a.max_o;
  assign max_w[1] = 32'(bus_c.max_o);
  assign val_w[0] = bus_a.period_valid_o;
  assign val_w[1] = bus_c.period_valid_o;
  assign ok_w[0]  = bus_a.ok_o;
  assign ok_w[1]  = bus_c.ok_o;
  assign sat_w[0] = bus_a.sat_o;
  assign sat_w[1] = bus_c.sat_o;
  assign ovr_w[0] = bus_a.overrun_o;
  assign ovr_w[1] = bus_c.overrun_o;

  longint maxv [2] = '{64'd4294967295, 64'd255};
  longint freq [2] = '{longint'(freq_a), longint'(freq_c)};
  longint tol  [2] = '{longint'(tol_a), longint'(tol_c)};

  item_t  q0 [$];
  item_t  q1 [$];
  longint ev0 [$];
  longint ev1 [$];

  function automatic void q_push(int d, item_t it);
    if (d == 0) q0.push_back(it); else q1.push_back(it);
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic item_t q_head(int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic void ev_push(int d, longint t);
    if (d == 0) ev0.push_back(t); else ev1.push_back(t);
  endfunction

  function automatic bit ev_due(int d, longint t);
    if (d == 0 && ev0.size() > 0 && ev0[0] == t) begin
      void'(ev0.pop_front());
      return 1'b1;
    end
    if (d == 1 && ev1.size() > 0 && ev1[0] == t) begin
      void'(ev1.pop_front());
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a sampled change of sig is an event; the interval between
  // consecutive events is the period, and the result lands two edges after the event.
  logic   prev_sig [2];
  bit     armed    [2];
  longint last_ev  [2];
  bit     m_valid  [2];
  bit     m_ovr    [2];
  longint m_min    [2];
  longint m_max    [2];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic   s;
      logic   r;
      bit     is_load;
      item_t  it;
      longint n;
      longint lo;
      s  = (d == 0) ? sig_a : sig_c;
      r  = (d == 0) ? rdy_a : rdy_c;
      lo = (freq[d] > tol[d]) ? freq[d] - tol[d] : 0;
      is_load = 1'b0;
      if (rst) begin
        prev_sig[d] = 1'b0;
        armed[d]    = 1'b0;
        m_valid[d]  = 1'b0;
        m_ovr[d]    = 1'b0;
        m_min[d]    = maxv[d];
        m_max[d]    = 0;
        if (d == 0) begin q0.delete(); ev0.delete(); end
        else begin q1.delete(); ev1.delete(); end
      end else begin
        if (ev_due(d, cyc - 2)) begin
          if (armed[d]) begin
            n         = cyc - 2 - last_ev[d];
            it.sat    = (n > maxv[d]);
            it.period = it.sat ? maxv[d] : n;
            it.ok     = !it.sat && (it.period >= lo) && (it.period <= freq[d] + tol[d]);
            it.load   = cyc;
            is_load   = 1'b1;
          end
          armed[d]   = 1'b1;
          last_ev[d] = cyc - 2;
        end
        if (is_load && (!m_valid[d] || r)) begin
          m_valid[d] = 1'b1;
          q_push(d, it);
          if (!it.sat) begin
            if (it.period < m_min[d]) m_min[d] = it.period;
            if (it.period > m_max[d]) m_max[d] = it.period;
          end
        end else begin
          if (is_load) m_ovr[d] = 1'b1;
          if (m_valid[d] && r) m_valid[d] = 1'b0;
        end
        if (s != prev_sig[d]) begin
          prev_sig[d] = s;
          ev_push(d, cyc);
        end
      end
    end
  end

  // Monitor: checks arrival time when a result first shows, data at handshake.
  bit pv [2] = '{1'b0, 1'b0};
  bit ph [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit    fresh;
      bit    hs;
      logic  r;
      item_t h;
      r = (d == 0) ? rdy_a : rdy_c;
      if (rst) begin
        pv[d] = 1'b0;
        ph[d] = 1'b0;
      end else begin
        fresh = val_w[d] && (!pv[d] || ph[d]);
        hs    = val_w[d] && r;
        if (fresh) begin
          if (q_size(d) == 0) begin
            check_output($sformatf("dut%0d unexpected result period", d), longint'(per_w[d]), -1);
          end else begin
            h = q_head(d);
            check_output($sformatf("dut%0d valid cycle", d), cyc, h.load);
          end
        end
        if (hs && q_size(d) > 0) begin
          h = q_head(d);
          check_output($sformatf("dut%0d period", d), longint'(per_w[d]), h.period);
          check_output($sformatf("dut%0d ok", d), longint'(ok_w[d]), longint'(h.ok));
          check_output($sformatf("dut%0d sat", d), longint'(sat_w[d]), longint'(h.sat));
          q_pop(d);
        end
        pv[d] = val_w[d];
        ph[d] = hs;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic toggle(input int d);
    if (d == 0) sig_a = ~sig_a; else sig_c = ~sig_c;
  endtask

  task automatic apply_stimulus(input int d, input int n);
    tick(n);
    toggle(d);
  endtask

  task automatic check_stats(input int d);
`ifdef BLINK_PERIOD_METER_STATS_EN
    check_output($sformatf("dut%0d min", d), longint'(min_w[d]), m_min[d]);
    check_output($sformatf("dut%0d max", d), longint'(max_w[d]), m_max[d]);
`else
    check_output($sformatf("dut%0d min", d), longint'(min_w[d]), maxv[d]);
    check_output($sformatf("dut%0d max", d), longint'(max_w[d]), 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick(2);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("dut%0d reset valid", d), longint'(val_w[d]), 0);
      check_output($sformatf("dut%0d reset period", d), longint'(per_w[d]), 0);
      check_output($sformatf("dut%0d reset ok", d), longint'(ok_w[d]), 0);
      check_output($sformatf("dut%0d reset sat", d), longint'(sat_w[d]), 0);
      check_output($sformatf("dut%0d reset overrun", d), longint'(ovr_w[d]), 0);
      check_output($sformatf("dut%0d reset min", d), longint'(min_w[d]), maxv[d]);
      check_output($sformatf("dut%0d reset max", d), longint'(max_w[d]), 0);
    end
    rst = 1'b0;
    tick(2);

    $display("[TB] nominal and boundary intervals, exact window");
    toggle(1);
    repeat (10) apply_stimulus(1, 50);
    apply_stimulus(1, 49);
    apply_stimulus(1, 51);
    apply_stimulus(1, 50);

    $display("[TB] stuck input saturates");
    apply_stimulus(1, 300);
    apply_stimulus(1, 50);

    $display("[TB] tolerance window +/-2");
    toggle(0);
    repeat (3) apply_stimulus(0, 1000);
    apply_stimulus(0, 998);
    apply_stimulus(0, 1002);
    apply_stimulus(0, 1003);
    apply_stimulus(0, 997);
    repeat (4) apply_stimulus(0, int'($urandom_range(990, 1010)));

    $display("[TB] random short intervals and back-to-back edges");
    repeat (8) apply_stimulus(1, int'($urandom_range(1, 60)));
    repeat (3) apply_stimulus(1, 1);

    $display("[TB] overrun while stalled");
    apply_stimulus(1, 20);
    tick(5);
    rdy_c = 1'b0;
    tick(5);
    toggle(1);
    apply_stimulus(1, 20);
    tick(10);
    check_output("dut1 stalled valid", longint'(val_w[1]), 1);
    check_output("dut1 stalled period", longint'(per_w[1]), 10);
    check_output("dut1 overrun set", longint'(ovr_w[1]), longint'(m_ovr[1]));
    rdy_c = 1'b1;
    tick(1);
    rdy_c = 1'b0;
    tick(1);
    check_output("dut1 valid after handshake", longint'(val_w[1]), 0);
    check_output("dut1 overrun sticky", longint'(ovr_w[1]), 1);
    rdy_c = 1'b1;
    tick(2);
    check_output("dut0 overrun clear", longint'(ovr_w[0]), longint'(m_ovr[0]));
    check_stats(0);
    check_stats(1);

    $display("[TB] reset mid-interval");
    if (sig_a) apply_stimulus(0, 7);
    if (sig_c) apply_stimulus(1, 7);
    tick(20);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(100);
    toggle(1);
    apply_stimulus(1, 50);
    tick(10);
    check_output("dut1 post-reset overrun", longint'(ovr_w[1]), 0);
    check_stats(1);
`ifdef BLINK_PERIOD_METER_STATS_EN
    check_output("dut1 post-reset min value", longint'(min_w[1]), 50);
`endif

    tick(10);
    check_output("dut0 results outstanding", longint'(q_size(0)), 0);
    check_output("dut1 results outstanding", longint'(q_size(1)), 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Sits directly downstream of the blinky LED toggler and consumes its blinky_o toggle output.
- Synchronises that output, measures the clk-cycle count between successive toggles, and flags each interval as within or outside tolerance of the expected 1 s.
- Results go out on a valid/ready port, so self-checking in hardware (on-board status LED, logic analyser, UART reporter) needs no simulation-time $time checks.

Parameters:
- clk_freq_hz, 50_000, clock frequency in Hz; expected interval = clk_freq_hz cycles (1 s per toggle).
- tol_cycles, 0, allowed absolute deviation from the expected interval, in cycles.
- cnt_w, 32, interval counter/result width; must satisfy 2^cnt_w-1 > clk_freq_hz+tol_cycles.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sig_i  in  1  blinky toggle input; may be asynchronous to clk.
- period_o  out  cnt_w  measured interval in clk cycles.
- period_valid_o  out  1  period_o/ok_o/sat_o hold a result.
- period_ready_i  in  1  consumer accepts the result when high together with period_valid_o.
- ok_o  out  1  result within [clk_freq_hz-tol_cycles, clk_freq_hz+tol_cycles] and not saturated.
- sat_o  out  1  counter saturated during this interval.
- overrun_o  out  1  sticky: a result was dropped because the output was still full.
- min_o  out  cnt_w  smallest accepted interval (optional feature).
- max_o  out  cnt_w  largest accepted interval (optional feature).

Behaviour:
- Reset: one clock, asynchronous active-high reset; every flop clears asynchronously.
  - All outputs reset to 0, except min_o, which resets to all-ones.
  - State returns to IDLE and the counter clears.
  - Reset mid-interval discards the partial measurement; the first edge after reset only arms.
- Synchroniser: 2-flop chain on sig_i (reset 0), plus one delay flop.
  - edge = sync_q ^ sync_d, so both toggle directions count.
  - Any sig_i change sampled on clock k gives edge high in cycle k+2.
- States:
  - IDLE --edge--> MEASURE; cnt <= 1; no result.
  - MEASURE, no edge: cnt <= cnt+1, saturating at 2^cnt_w-1; saturation sets an internal sat flag.
  - MEASURE, edge: capture cnt as the result; cnt <= 1; sat flag clears; stays in MEASURE.
- Interval arithmetic: two edges N cycles apart yield period = N.
  - ok = !sat && (period >= clk_freq_hz-tol_cycles) && (period <= clk_freq_hz+tol_cycles).
  - Compare in cnt_w+1 bits; a lower bound below 0 clamps to 0.
- Output register:
  - Captured result appears on period_o/ok_o/sat_o with period_valid_o=1 in the cycle after the edge.
  - Total latency from sig_i sample to valid: 3 clocks.
  - Outputs stay stable while valid && !ready.
  - valid clears on handshake unless a new result loads in the same cycle; then valid stays 1 with the new data.
  - Capture while valid && !ready: new result dropped, old one held, overrun_o set to 1 until reset.
- sig_i stuck: counter saturates; the next edge reports period=2^cnt_w-1, sat_o=1, ok_o=0.
- Edges in consecutive cycles: each produces a result (period=1), subject to the overrun rule.

Optional Feature:
- Macro: BLINK_PERIOD_METER_STATS_EN.
- Defined: on each result accepted into the output register (not dropped), min_o/max_o update with min/max of (current, period) when sat=0.
  - Saturated results are excluded.
  - Values are registered, visible the cycle after the result loads.
- Undefined: min_o/max_o ports still exist; min_o tied to all-ones, max_o to 0; no stats logic synthesised.

Decomposition:
- Shared package blink_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_MEASURE=1'b1.
  - default cnt_w.
  - helper function computing the clamped tolerance bounds.
- One sub-module: sync_edge_det (2-flop synchroniser + delay flop + XOR edge output, async active-high reset).
  - Reusable by other board-input stages.

Test Plan:
- clk_freq_hz=50_000, tol 0; sig_i toggles every 50_000 cycles, ready=1 -> 10 results, each period_o=50000, ok_o=1, sat_o=0, overrun_o=0; valid exactly 3 clocks after each sig_i change sampled.
- tol_cycles=2; intervals 49_998, 50_002, 50_003 -> ok_o = 1, 1, 0.
- cnt_w=8; hold sig_i for 300 cycles, then toggle -> period_o=255, sat_o=1, ok_o=0; next 50-cycle interval -> period_o=50, sat_o=0.
- ready=0; two intervals of 10 then 20 cycles -> valid stays with period_o=10, overrun_o=1; then ready=1 for one cycle -> valid drops, overrun_o stays 1.
- Assert rst mid-interval, release, toggle at +100, +150 -> first toggle yields no result; second yields period_o=50; min_o=50, max_o=50 with BLINK_PERIOD_METER_STATS_EN, all-ones/0 without.
